// File: rtl/rv_mc_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// opcode and funct3 encodings, sequencer state encoding and trap-cause codes.
package rv_mc_control_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store width funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL      = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN_LS  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN_TGT = 2'd2;

endpackage

// File: rtl/rv_mc_control_imm_decode.sv
// Combinational instruction decode for the multi-cycle sequencer.
// Ports:
//   ir                       in  32  instruction register
//   imm_i/s/b/u/j            out 32  sign-extended immediates per format
//   is_lui .. is_op          out 1   instruction class flags
//   illegal                  out 1   opcode is not a supported RV32I class
module rv_imm_decode
  import rv_mc_control_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store,
  output logic        is_opimm,
  output logic        is_op,
  output logic        illegal
);

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_lui    = (ir[6:0] == OP_LUI);
  assign is_auipc  = (ir[6:0] == OP_AUIPC);
  assign is_jal    = (ir[6:0] == OP_JAL);
  assign is_jalr   = (ir[6:0] == OP_JALR);
  assign is_branch = (ir[6:0] == OP_BRANCH);
  assign is_load   = (ir[6:0] == OP_LOAD);
  assign is_store  = (ir[6:0] == OP_STORE);
  assign is_opimm  = (ir[6:0] == OP_IMM);
  assign is_op     = (ir[6:0] == OP_OP);

  assign illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                     is_load || is_store || is_opimm || is_op);

endmodule

// File: rtl/rv_mc_control.sv
// Multi-cycle RV32I control sequencer: owns PC and IR, drives an external ALU
// and register file, and talks to instruction/data memory over req/ack.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   imem_req_out/addr_out/ack_in/data_in  instruction fetch handshake
//   dmem_req_out/we_out/addr_out/wstrb_out/wdata_out/ack_in/rdata_in
//                                         data memory handshake
//   reg_rd_idx1/2_out, reg_rd_data1/2_in  register file read (combinational)
//   reg_wr_en/idx/data_out                register file write, one-cycle strobe
//   alu_cid_out/arg1_out/arg2_out/res_in  external ALU command and operands
//   pc_out, trap_out, trap_cause_out      current PC, sticky trap flag + cause
module rv_mc_control
  import rv_mc_control_pkg::*;
#(
  parameter int               XLEN          = 32,
  parameter logic [XLEN-1:0]  RESET_PC      = '0,
  parameter bit               MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_out,
  output logic [XLEN-1:0]   imem_addr_out,
  input  logic              imem_ack_in,
  input  logic [31:0]       imem_data_in,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [XLEN-1:0]   dmem_addr_out,
  output logic [XLEN/8-1:0] dmem_wstrb_out,
  output logic [XLEN-1:0]   dmem_wdata_out,
  input  logic              dmem_ack_in,
  input  logic [XLEN-1:0]   dmem_rdata_in,
  output logic [4:0]        reg_rd_idx1_out,
  output logic [4:0]        reg_rd_idx2_out,
  input  logic [XLEN-1:0]   reg_rd_data1_in,
  input  logic [XLEN-1:0]   reg_rd_data2_in,
  output logic              reg_wr_en_out,
  output logic [4:0]        reg_wr_idx_out,
  output logic [XLEN-1:0]   reg_wr_data_out,
  output logic [9:0]        alu_cid_out,
  output logic [XLEN-1:0]   alu_arg1_out,
  output logic [XLEN-1:0]   alu_arg2_out,
  input  logic [XLEN-1:0]   alu_res_in,
  output logic [XLEN-1:0]   pc_out,
  output logic              trap_out,
  output logic [1:0]        trap_cause_out
);

  state_t          state;
  logic [XLEN-1:0] pc, a_q, b_q, wb_data, next_pc, mem_addr;
  logic [31:0]     ir;
  logic            trap;
  logic [1:0]      cause;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_opimm, is_op, illegal;

  rv_imm_decode u_dec (
    .ir(ir), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_u(imm_u), .imm_j(imm_j),
    .is_lui(is_lui), .is_auipc(is_auipc), .is_jal(is_jal), .is_jalr(is_jalr),
    .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
    .is_opimm(is_opimm), .is_op(is_op), .illegal(illegal)
  );

  logic [2:0] funct3;
  logic [4:0] rd;
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];

  function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] as, bs;
    as = a;
    bs = b;
    case (f3)
      F3_BEQ:  br_taken = (a == b);
      F3_BNE:  br_taken = (a != b);
      F3_BLT:  br_taken = (as < bs);
      F3_BGE:  br_taken = (as >= bs);
      F3_BLTU: br_taken = (a < b);
      F3_BGEU: br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                               input logic [XLEN-1:0] word);
    logic [XLEN-1:0] s;
    s = word >> {ofs, 3'b000};
    case (f3)
      F3_B:    load_ext = {{24{s[7]}}, s[7:0]};
      F3_H:    load_ext = {{16{s[15]}}, s[15:0]};
      F3_BU:   load_ext = {24'b0, s[7:0]};
      F3_HU:   load_ext = {16'b0, s[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << ofs;
      2'b01:   store_strb = 4'b0011 << {ofs[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Execute-stage address arithmetic
  logic [XLEN-1:0] pc_plus4, jalr_sum, tgt, tgt_fixed, ls_addr, ls_mask;
  logic            tgt_misal, ls_misal, taken;

  assign pc_plus4  = pc + 32'd4;
  assign jalr_sum  = a_q + imm_i;
  assign taken     = br_taken(funct3, a_q, b_q);
  assign tgt       = is_jal  ? pc + imm_j :
                     is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm_b;
  assign tgt_misal = |tgt[1:0];
  // With trapping disabled a misaligned target just loses its low bits; when
  // trapping is enabled only aligned targets get here, so clearing is a no-op.
  assign tgt_fixed = {tgt[XLEN-1:2], 2'b00};
  assign ls_addr   = a_q + (is_store ? imm_s : imm_i);
  assign ls_misal  = (funct3[1:0] == 2'b01) ? ls_addr[0] :
                     (funct3[1:0] == 2'b10) ? |ls_addr[1:0] : 1'b0;
  assign ls_mask   = (funct3[1:0] == 2'b01) ? {{(XLEN-1){1'b1}}, 1'b0} :
                     (funct3[1:0] == 2'b10) ? {{(XLEN-2){1'b1}}, 2'b00} : '1;

  // Output decode; requests are gated by rst so they drop as soon as reset is seen
  assign imem_req_out    = !rst && (state == ST_FETCH);
  assign imem_addr_out   = pc;
  assign dmem_req_out    = !rst && (state == ST_MEM);
  assign dmem_we_out     = dmem_req_out && is_store;
  assign dmem_addr_out   = mem_addr;
  assign dmem_wstrb_out  = dmem_we_out ? store_strb(funct3, mem_addr[1:0]) : 4'b0000;
  assign dmem_wdata_out  = (funct3[1:0] == 2'b00) ? {4{b_q[7:0]}} :
                           (funct3[1:0] == 2'b01) ? {2{b_q[15:0]}} : b_q;
  assign reg_rd_idx1_out = ir[19:15];
  assign reg_rd_idx2_out = ir[24:20];
  assign reg_wr_en_out   = !rst && (state == ST_WB) && (rd != 5'd0);
  assign reg_wr_idx_out  = rd;
  assign reg_wr_data_out = wb_data;
  // funct7 only carries meaning for R-type and immediate shifts (SRAI vs SRLI)
  assign alu_cid_out     = {funct3, (is_op || (is_opimm && funct3[1:0] == 2'b01)) ? ir[31:25] : 7'b0};
  assign alu_arg1_out    = a_q;
  assign alu_arg2_out    = is_op ? b_q :
                           (funct3[1:0] == 2'b01) ? {27'b0, ir[24:20]} : imm_i;
  assign pc_out          = pc;
  assign trap_out        = trap;
  assign trap_cause_out  = cause;

  // Control state: sequencer, PC, IR and trap status
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      trap  <= 1'b0;
      cause <= CAUSE_ILLEGAL;
    end else begin
      case (state)
        ST_FETCH: if (imem_ack_in) begin
          ir    <= imem_data_in;
          state <= ST_DECODE;
        end
        ST_DECODE: if (illegal) begin
          state <= ST_TRAP;
          trap  <= 1'b1;
          cause <= CAUSE_ILLEGAL;
        end else begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_branch) begin
            if (taken && tgt_misal && MISALIGN_TRAP) begin
              state <= ST_TRAP;
              trap  <= 1'b1;
              cause <= CAUSE_MISALIGN_TGT;
            end else begin
              pc    <= taken ? tgt_fixed : pc_plus4;
              state <= ST_FETCH;
            end
          end else if (is_jal || is_jalr) begin
            if (tgt_misal && MISALIGN_TRAP) begin
              state <= ST_TRAP;
              trap  <= 1'b1;
              cause <= CAUSE_MISALIGN_TGT;
            end else begin
              state <= ST_WB;
            end
          end else if (is_load || is_store) begin
            if (ls_misal && MISALIGN_TRAP) begin
              state <= ST_TRAP;
              trap  <= 1'b1;
              cause <= CAUSE_MISALIGN_LS;
            end else begin
              state <= ST_MEM;
            end
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: if (dmem_ack_in) begin
          if (is_store) begin
            pc    <= next_pc;
            state <= ST_FETCH;
          end else begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          pc    <= next_pc;
          state <= ST_FETCH;
        end
        default: state <= ST_TRAP;
      endcase
    end
  end

  // Datapath holding registers (no reset: always written before use)
  always_ff @(posedge clk) begin
    case (state)
      ST_DECODE: begin
        a_q <= reg_rd_data1_in;
        b_q <= reg_rd_data2_in;
      end
      ST_EXEC: begin
        next_pc  <= (is_jal || is_jalr) ? tgt_fixed : pc_plus4;
        mem_addr <= ls_addr & ls_mask;
        wb_data  <= (is_jal || is_jalr) ? pc_plus4 :
                    is_lui              ? imm_u :
                    is_auipc            ? pc + imm_u : alu_res_in;
      end
      ST_MEM: if (dmem_ack_in && !is_store) begin
        wb_data <= load_ext(funct3, mem_addr[1:0], dmem_rdata_in);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_control.sv
module tb_rv_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_out, imem_ack_in;
  logic [31:0] imem_addr_out, imem_data_in;
  logic        dmem_req_out, dmem_we_out, dmem_ack_in;
  logic [31:0] dmem_addr_out, dmem_wdata_out, dmem_rdata_in;
  logic [3:0]  dmem_wstrb_out;
  logic [4:0]  reg_rd_idx1_out, reg_rd_idx2_out, reg_wr_idx_out;
  logic [31:0] reg_rd_data1_in, reg_rd_data2_in, reg_wr_data_out;
  logic        reg_wr_en_out;
  logic [9:0]  alu_cid_out;
  logic [31:0] alu_arg1_out, alu_arg2_out, alu_res_in, pc_out;
  logic        trap_out;
  logic [1:0]  trap_cause_out;

  always #5 clk = ~clk;

  rv_mc_control dut (
    .clk(clk), .rst(rst),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wstrb_out(dmem_wstrb_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_ack_in(dmem_ack_in),
    .dmem_rdata_in(dmem_rdata_in),
    .reg_rd_idx1_out(reg_rd_idx1_out), .reg_rd_idx2_out(reg_rd_idx2_out),
    .reg_rd_data1_in(reg_rd_data1_in), .reg_rd_data2_in(reg_rd_data2_in),
    .reg_wr_en_out(reg_wr_en_out), .reg_wr_idx_out(reg_wr_idx_out),
    .reg_wr_data_out(reg_wr_data_out),
    .alu_cid_out(alu_cid_out), .alu_arg1_out(alu_arg1_out),
    .alu_arg2_out(alu_arg2_out), .alu_res_in(alu_res_in),
    .pc_out(pc_out), .trap_out(trap_out), .trap_cause_out(trap_cause_out)
  );

  // Instruction memory with programmable wait states
  logic [31:0] imem [64];
  int          imem_delay = 0;
  int          iwait = 0;
  assign imem_data_in = imem[imem_addr_out[7:2]];
  assign imem_ack_in  = imem_req_out && (iwait >= imem_delay);
  always @(posedge clk) begin
    if (rst || !imem_req_out || imem_ack_in) iwait <= 0;
    else                                     iwait <= iwait + 1;
  end

  // Zero-wait data memory
  assign dmem_ack_in = dmem_req_out;

  // Register file model with preset port
  logic [31:0] rf [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          wr_cnt = 0, dreq_cnt = 0, iack_cnt = 0;
  assign reg_rd_data1_in = (reg_rd_idx1_out == 5'd0) ? 32'd0 : rf[reg_rd_idx1_out];
  assign reg_rd_data2_in = (reg_rd_idx2_out == 5'd0) ? 32'd0 : rf[reg_rd_idx2_out];
  always @(posedge clk) begin
    if (pre_we) rf[pre_idx] <= pre_val;
    else if (reg_wr_en_out && reg_wr_idx_out != 5'd0) rf[reg_wr_idx_out] <= reg_wr_data_out;
    if (reg_wr_en_out) wr_cnt <= wr_cnt + 1;
    if (dmem_req_out) dreq_cnt <= dreq_cnt + 1;
    if (imem_req_out && imem_ack_in) iack_cnt <= iack_cnt + 1;
  end

  // Reference ALU: cid = {funct3, funct7}
  always_comb begin
    alu_res_in = '0;
    case (alu_cid_out[9:7])
      3'd0: alu_res_in = alu_cid_out[5] ? alu_arg1_out - alu_arg2_out : alu_arg1_out + alu_arg2_out;
      3'd1: alu_res_in = alu_arg1_out << alu_arg2_out[4:0];
      3'd2: alu_res_in = {31'd0, $signed(alu_arg1_out) < $signed(alu_arg2_out)};
      3'd3: alu_res_in = {31'd0, alu_arg1_out < alu_arg2_out};
      3'd4: alu_res_in = alu_arg1_out ^ alu_arg2_out;
      3'd5: alu_res_in = alu_cid_out[5] ? 32'($signed(alu_arg1_out) >>> alu_arg2_out[4:0])
                                        : alu_arg1_out >> alu_arg2_out[4:0];
      3'd6: alu_res_in = alu_arg1_out | alu_arg2_out;
      3'd7: alu_res_in = alu_arg1_out & alu_arg2_out;
      default: alu_res_in = '0;
    endcase
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    pre_we  = 1'b1;
    pre_idx = idx[4:0];
    pre_val = v;
    cyc();
    pre_we  = 1'b0;
  endtask

  // Fill with JAL x0,0 so the core parks harmlessly after each program
  task automatic prog_clear();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000006F;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    dmem_rdata_in = '0;
    prog_clear();

    // 1: ADDI x1,x0,5 with zero-wait fetch
    imem[0] = 32'h00500093;
    cyc(2);
    chk("rst_imem_req", {31'd0, imem_req_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_trap", {31'd0, trap_out}, 32'd0);
    chk("rst_cause", {30'd0, trap_cause_out}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req_out}, 32'd0);
    chk("rst_wr_en", {31'd0, reg_wr_en_out}, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb_out}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_req_c0", {31'd0, imem_req_out}, 32'd1);
    cyc();
    chk("t1_req_c1", {31'd0, imem_req_out}, 32'd0);
    chk("t1_wr_c1", {31'd0, reg_wr_en_out}, 32'd0);
    cyc();
    chk("t1_wr_c2", {31'd0, reg_wr_en_out}, 32'd0);
    cyc();
    chk("t1_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("t1_wr_idx", {27'd0, reg_wr_idx_out}, 32'd1);
    chk("t1_wr_data", reg_wr_data_out, 32'd5);
    chk("t1_pc_wb", pc_out, 32'd0);
    cyc();
    chk("t1_wr_off", {31'd0, reg_wr_en_out}, 32'd0);
    chk("t1_pc_next", pc_out, 32'd4);

    // 2: ADDI x3,x2,1 with three fetch wait states
    rst = 1'b1;
    prog_clear();
    imem[0] = 32'h00110193;
    imem_delay = 3;
    set_reg(2, 32'd10);
    cyc();
    base = iack_cnt;
    rst = 1'b0;
    #1;
    chk("t2_req_c0", {31'd0, imem_req_out}, 32'd1);
    chk("t2_ack_c0", {31'd0, imem_ack_in}, 32'd0);
    cyc();
    chk("t2_req_c1", {31'd0, imem_req_out}, 32'd1);
    cyc();
    chk("t2_req_c2", {31'd0, imem_req_out}, 32'd1);
    cyc();
    chk("t2_req_c3", {31'd0, imem_req_out}, 32'd1);
    chk("t2_ack_c3", {31'd0, imem_ack_in}, 32'd1);
    chk("t2_ir_before_ack", {27'd0, reg_rd_idx1_out}, 32'd0);
    cyc();
    chk("t2_req_dropped", {31'd0, imem_req_out}, 32'd0);
    chk("t2_ir_after_ack", {27'd0, reg_rd_idx1_out}, 32'd2);
    cyc(2);
    chk("t2_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("t2_wr_idx", {27'd0, reg_wr_idx_out}, 32'd3);
    chk("t2_wr_data", reg_wr_data_out, 32'd11);
    chk("t2_fetch_count", iack_cnt - base, 32'd1);

    // 3: SB x2,1(x0); LBU x4,3(x0); LB x5,3(x0)
    rst = 1'b1;
    imem_delay = 0;
    prog_clear();
    imem[0] = 32'h002000A3;
    imem[1] = 32'h00304203;
    imem[2] = 32'h00300283;
    dmem_rdata_in = 32'h80000000;
    set_reg(2, 32'h123456AB);
    cyc();
    rst = 1'b0;
    #1;
    cyc(3);
    chk("t3_sb_req", {31'd0, dmem_req_out}, 32'd1);
    chk("t3_sb_we", {31'd0, dmem_we_out}, 32'd1);
    chk("t3_sb_strb", {28'd0, dmem_wstrb_out}, 32'h2);
    chk("t3_sb_wdata", dmem_wdata_out, 32'hABABABAB);
    chk("t3_sb_addr", dmem_addr_out, 32'd1);
    cyc();
    chk("t3_sb_pc", pc_out, 32'd4);
    chk("t3_sb_req_off", {31'd0, dmem_req_out}, 32'd0);
    cyc(3);
    chk("t3_lbu_req", {31'd0, dmem_req_out}, 32'd1);
    chk("t3_lbu_we", {31'd0, dmem_we_out}, 32'd0);
    chk("t3_lbu_addr", dmem_addr_out, 32'd3);
    chk("t3_lbu_strb", {28'd0, dmem_wstrb_out}, 32'd0);
    cyc();
    chk("t3_lbu_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("t3_lbu_idx", {27'd0, reg_wr_idx_out}, 32'd4);
    chk("t3_lbu_data", reg_wr_data_out, 32'h00000080);
    cyc(5);
    chk("t3_lb_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("t3_lb_idx", {27'd0, reg_wr_idx_out}, 32'd5);
    chk("t3_lb_data", reg_wr_data_out, 32'hFFFFFF80);

    // 4: ADDI then misaligned LW x6,2(x0) traps at pc 4
    rst = 1'b1;
    prog_clear();
    imem[0] = 32'h00500093;
    imem[1] = 32'h00202303;
    cyc(2);
    base = dreq_cnt;
    rst = 1'b0;
    #1;
    cyc(7);
    chk("t4_trap", {31'd0, trap_out}, 32'd1);
    chk("t4_cause", {30'd0, trap_cause_out}, 32'd1);
    chk("t4_pc", pc_out, 32'd4);
    chk("t4_imem_req", {31'd0, imem_req_out}, 32'd0);
    cyc(2);
    chk("t4_trap_held", {31'd0, trap_out}, 32'd1);
    chk("t4_pc_frozen", pc_out, 32'd4);
    chk("t4_no_dmem_req", dreq_cnt - base, 32'd0);
    rst = 1'b1;
    cyc();
    chk("t4_rst_pc", pc_out, 32'd0);
    chk("t4_rst_trap", {31'd0, trap_out}, 32'd0);

    // 5: BLT taken (+8) skips an ADDI; BLTU on same operands not taken
    prog_clear();
    imem[0] = 32'h0020C463;
    imem[1] = 32'h00500093;
    imem[2] = 32'h0020E463;
    set_reg(1, 32'hFFFFFFFF);
    set_reg(2, 32'd1);
    base = wr_cnt;
    rst = 1'b0;
    #1;
    cyc(3);
    chk("t5_blt_pc", pc_out, 32'd8);
    cyc(3);
    chk("t5_bltu_pc", pc_out, 32'd12);
    chk("t5_no_wr", wr_cnt - base, 32'd0);

    // 6: ADDI x0,x0,7 writes nothing; opcode 0 traps illegal
    rst = 1'b1;
    prog_clear();
    imem[0] = 32'h00700013;
    imem[1] = 32'h00000000;
    cyc(2);
    base = wr_cnt;
    rst = 1'b0;
    #1;
    cyc(3);
    chk("t6_x0_wr_en", {31'd0, reg_wr_en_out}, 32'd0);
    cyc();
    chk("t6_pc", pc_out, 32'd4);
    cyc(2);
    chk("t6_trap", {31'd0, trap_out}, 32'd1);
    chk("t6_cause", {30'd0, trap_cause_out}, 32'd0);
    cyc(3);
    chk("t6_pc_frozen", pc_out, 32'd4);
    chk("t6_imem_req", {31'd0, imem_req_out}, 32'd0);
    chk("t6_no_wr", wr_cnt - base, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
